// File: rtl/packet_arbiter_pkg.sv
// Shared types for the packet arbiter: packet payload, FSM state, counter widths.
package packet_arbiter_pkg;

    localparam int unsigned PKT_W       = 13;
    localparam int unsigned BURST_CNT_W = 4;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] tag;
        logic       valid;
    } packet_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

endpackage

// File: rtl/packet_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request bit at or after a pointer,
// wrapping modulo N; returns a one-hot grant and its index.
module packet_arbiter_rr_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt_oh,
    output logic [IDX_W-1:0] o_gnt_idx,
    output logic             o_any
);

    logic [IDX_W-1:0] w_lane;

    always_comb begin
        o_gnt_oh  = '0;
        o_gnt_idx = '0;
        o_any     = 1'b0;
        w_lane    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_lane = IDX_W'((32'(i_ptr) + k) % N);
            if (!o_any && i_req[w_lane]) begin
                o_any          = 1'b1;
                o_gnt_idx      = w_lane;
                o_gnt_oh[w_lane] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/packet_arbiter.sv
// Round-robin packet arbiter with bounded bursts, a single registered output
// slot and per-lane saturating counters of consumed invalid packets.
module packet_arbiter
    import packet_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  packet_t                    req_pkt [NUM_REQ],
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       out_valid,
    output packet_t                    out_pkt,
    output logic [$clog2(NUM_REQ)-1:0] out_src,
    input  logic                       out_ready,
    output logic [CNT_W-1:0]           drop_count [NUM_REQ]
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    state_t                  r_state;
    logic [IDX_W-1:0]        r_owner;
    logic [BURST_CNT_W-1:0]  r_burst_cnt;
    logic [IDX_W-1:0]        r_rr_ptr;
    logic                    r_out_valid;
    packet_t                 r_out_pkt;
    logic [IDX_W-1:0]        r_out_src;
    logic [CNT_W-1:0]        r_drop_count [NUM_REQ];

    logic [NUM_REQ-1:0]      w_rr_oh;
    logic [IDX_W-1:0]        w_rr_idx;
    logic                    w_rr_any;
    logic                    w_slot_free;
    logic                    w_hold;
    logic [IDX_W-1:0]        w_gnt_idx;
    logic [NUM_REQ-1:0]      w_gnt_oh;
    logic                    w_accept;
    logic                    w_new_grant;
    packet_t                 w_acc_pkt;
    logic [IDX_W-1:0]        w_next_ptr;
    logic [BURST_CNT_W-1:0]  w_cnt_inc;

    packet_arbiter_rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req     (req_valid),
        .i_ptr     (r_rr_ptr),
        .o_gnt_oh  (w_rr_oh),
        .o_gnt_idx (w_rr_idx),
        .o_any     (w_rr_any)
    );

    // Burst owner keeps the grant while it requests; otherwise round-robin from rr_ptr.
    always_comb begin
        w_slot_free = !r_out_valid || out_ready;
        w_hold      = (r_state == BURST) && req_valid[r_owner];
        w_gnt_idx   = w_hold ? r_owner : w_rr_idx;
        w_gnt_oh    = w_hold ? (NUM_REQ'(1) << r_owner) : w_rr_oh;
        w_accept    = !rst && w_slot_free && (w_hold || w_rr_any);
        w_new_grant = w_accept && !w_hold;
        req_ready   = w_accept ? w_gnt_oh : '0;
        w_acc_pkt   = req_pkt[w_gnt_idx];
        w_next_ptr  = (w_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + IDX_W'(1);
        w_cnt_inc   = r_burst_cnt + BURST_CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_owner     <= '0;
            r_burst_cnt <= '0;
            r_rr_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_pkt   <= '0;
            r_out_src   <= '0;
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                r_drop_count[i] <= '0;
            end
        end else begin
            // Output slot: load valid packets, drain otherwise.
            if (w_accept && w_acc_pkt.valid) begin
                r_out_valid <= 1'b1;
                r_out_pkt   <= w_acc_pkt;
                r_out_src   <= w_gnt_idx;
            end else if (w_slot_free) begin
                r_out_valid <= 1'b0;
            end

            if (w_accept && !w_acc_pkt.valid && (r_drop_count[w_gnt_idx] != '1)) begin
                r_drop_count[w_gnt_idx] <= r_drop_count[w_gnt_idx] + CNT_W'(1);
            end

            // A fresh grant (from IDLE or after the owner went quiet) opens a burst.
            if (w_new_grant) begin
                r_rr_ptr <= w_next_ptr;
                if (MAX_BURST > 1) begin
                    r_state     <= BURST;
                    r_owner     <= w_gnt_idx;
                    r_burst_cnt <= BURST_CNT_W'(1);
                end else begin
                    r_state <= IDLE;
                end
            end else if (w_hold) begin
                if (w_accept) begin
                    r_burst_cnt <= w_cnt_inc;
                    if (w_cnt_inc == BURST_CNT_W'(MAX_BURST)) begin
                        r_state <= IDLE;
                    end
                end
            end else if (r_state == BURST) begin
                r_state <= IDLE;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_pkt    = r_out_pkt;
    assign out_src    = r_out_src;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_packet_arbiter.sv
// Directed table-driven bench for packet_arbiter plus hand-written multi-cycle sequences.
module tb_packet_arbiter;
    import packet_arbiter_pkg::*;

    localparam int unsigned NR = 4;
    localparam int unsigned MB = 4;
    localparam int unsigned CW = 8;
    localparam int unsigned IW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [NR-1:0]  req_valid;
    packet_t        req_pkt [NR];
    logic [NR-1:0]  req_ready;
    logic           out_valid;
    packet_t        out_pkt;
    logic [IW-1:0]  out_src;
    logic           out_ready;
    logic [CW-1:0]  drop_count [NR];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    packet_arbiter #(
        .NUM_REQ   (NR),
        .MAX_BURST (MB),
        .CNT_W     (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_pkt    (req_pkt),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_pkt    (out_pkt),
        .out_src    (out_src),
        .out_ready  (out_ready),
        .drop_count (drop_count)
    );

    typedef struct {
        logic       r;
        logic [3:0] v;
        logic       pv;
        logic [7:0] d;
        logic       ordy;
        logic [3:0] e_rdy;
        logic       e_ov;
        logic [1:0] e_src;
        logic [7:0] e_dat;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic pv,
                                input logic [7:0] d, input logic ordy, input logic [3:0] e_rdy,
                                input logic e_ov, input logic [1:0] e_src, input logic [7:0] e_dat);
        vec_t t;
        t.r = r; t.v = v; t.pv = pv; t.d = d; t.ordy = ordy;
        t.e_rdy = e_rdy; t.e_ov = e_ov; t.e_src = e_src; t.e_dat = e_dat;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] v, input logic pv,
                         input logic [7:0] d, input logic ordy);
        rst       = r;
        req_valid = v;
        out_ready = ordy;
        for (int i = 0; i < int'(NR); i++) begin
            req_pkt[i] = '{data: d, tag: 4'(i), valid: pv};
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic seen_ov;
        drive(1'b1, 4'b0000, 1'b1, 8'h00, 1'b1);
        step();

        // Single lane 2, six packets, no backpressure.
        tbl.push_back(mk(1, 4'b0000, 1, 8'h00, 1, 4'b0000, 0, 2'd0, 8'h00));
        for (int k = 0; k < 6; k++) begin
            tbl.push_back(mk(0, 4'b0100, 1, 8'(8'h10 + k), 1, 4'b0100, 1, 2'd2, 8'(8'h10 + k)));
        end
        tbl.push_back(mk(0, 4'b0000, 1, 8'h00, 1, 4'b0000, 0, 2'd0, 8'h00));
        // All lanes requesting: bursts of four per lane, then wrap.
        tbl.push_back(mk(1, 4'b0000, 1, 8'h00, 1, 4'b0000, 0, 2'd0, 8'h00));
        for (int k = 0; k < 17; k++) begin
            tbl.push_back(mk(0, 4'b1111, 1, 8'(8'h20 + k), 1, 4'(1 << ((k / 4) % 4)),
                             1, 2'((k / 4) % 4), 8'(8'h20 + k)));
        end
        // Early burst end: lane 1 twice, lane 3 follows with no gap.
        tbl.push_back(mk(1, 4'b0000, 1, 8'h00, 1, 4'b0000, 0, 2'd0, 8'h00));
        tbl.push_back(mk(0, 4'b1010, 1, 8'h40, 1, 4'b0010, 1, 2'd1, 8'h40));
        tbl.push_back(mk(0, 4'b1010, 1, 8'h41, 1, 4'b0010, 1, 2'd1, 8'h41));
        tbl.push_back(mk(0, 4'b1000, 1, 8'h42, 1, 4'b1000, 1, 2'd3, 8'h42));
        tbl.push_back(mk(0, 4'b0000, 1, 8'h00, 1, 4'b0000, 0, 2'd0, 8'h00));
        // Valid packet then a drop from the same lane: slot drains, nothing forwarded.
        tbl.push_back(mk(0, 4'b0001, 1, 8'h51, 1, 4'b0001, 1, 2'd0, 8'h51));
        tbl.push_back(mk(0, 4'b0001, 0, 8'h52, 1, 4'b0001, 0, 2'd0, 8'h00));

        foreach (tbl[k]) begin
            drive(tbl[k].r, tbl[k].v, tbl[k].pv, tbl[k].d, tbl[k].ordy);
            #1;
            chk($sformatf("v%0d.req_ready", k), 32'(req_ready), 32'(tbl[k].e_rdy));
            step();
            chk($sformatf("v%0d.out_valid", k), 32'(out_valid), 32'(tbl[k].e_ov));
            if (tbl[k].e_ov || tbl[k].r) begin
                chk($sformatf("v%0d.out_src", k), 32'(out_src), 32'(tbl[k].e_src));
                chk($sformatf("v%0d.out_data", k), 32'(out_pkt.data), 32'(tbl[k].e_dat));
                chk($sformatf("v%0d.out_tag", k), 32'(out_pkt.tag), tbl[k].r ? 32'd0 : 32'(tbl[k].e_src));
            end
        end
        chk("table.drop_count0", 32'(drop_count[0]), 32'd1);

        // Backpressure: held packet stable, no ready while stalled.
        drive(1'b1, 4'b0000, 1'b1, 8'h00, 1'b1);
        step();
        drive(1'b0, 4'b0100, 1'b1, 8'hA5, 1'b1);
        #1;
        chk("bp.first_ready", 32'(req_ready), 32'b0100);
        step();
        chk("bp.first_out", 32'(out_pkt.data), 32'hA5);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 4'b0101, 1'b1, 8'hB0, 1'b0);
            #1;
            chk($sformatf("bp%0d.ready", k), 32'(req_ready), 32'd0);
            step();
            chk($sformatf("bp%0d.valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d.data", k), 32'(out_pkt.data), 32'hA5);
            chk($sformatf("bp%0d.src", k), 32'(out_src), 32'd2);
        end
        drive(1'b0, 4'b0101, 1'b1, 8'hB0, 1'b1);
        #1;
        chk("bp.release_ready", 32'(req_ready), 32'b0100);
        chk("bp.release_data", 32'(out_pkt.data), 32'hA5);
        step();
        chk("bp.next_data", 32'(out_pkt.data), 32'hB0);
        chk("bp.next_src", 32'(out_src), 32'd2);
        drive(1'b0, 4'b0000, 1'b1, 8'h00, 1'b1);
        step();
        chk("bp.drained", 32'(out_valid), 32'd0);

        // Drop counting: 300 invalid packets saturate the 8-bit counter.
        drive(1'b1, 4'b0000, 1'b1, 8'h00, 1'b1);
        step();
        drive(1'b0, 4'b0001, 1'b0, 8'h77, 1'b1);
        seen_ov = 1'b0;
        for (int k = 0; k < 300; k++) begin
            step();
            if (out_valid !== 1'b0) seen_ov = 1'b1;
            if (k == 0)   chk("drop.first", 32'(drop_count[0]), 32'd1);
            if (k == 253) chk("drop.254", 32'(drop_count[0]), 32'd254);
            if (k == 254) chk("drop.255", 32'(drop_count[0]), 32'd255);
        end
        chk("drop.saturated", 32'(drop_count[0]), 32'd255);
        chk("drop.other_lane", 32'(drop_count[1]), 32'd0);
        chk("drop.never_valid", 32'(seen_ov), 32'd0);

        // Reset mid-burst: lane 0 regains top priority afterwards.
        drive(1'b1, 4'b0000, 1'b1, 8'h00, 1'b1);
        step();
        chk("rst.drop_cleared", 32'(drop_count[0]), 32'd0);
        drive(1'b0, 4'b0010, 1'b1, 8'h61, 1'b1);
        step();
        drive(1'b0, 4'b0010, 1'b1, 8'h62, 1'b1);
        step();
        chk("rst.burst_src", 32'(out_src), 32'd1);
        chk("rst.burst_data", 32'(out_pkt.data), 32'h62);
        drive(1'b1, 4'b0011, 1'b1, 8'h63, 1'b1);
        #1;
        chk("rst.ready_in_reset", 32'(req_ready), 32'd0);
        step();
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out_src", 32'(out_src), 32'd0);
        chk("rst.out_pkt", 32'(out_pkt), 32'd0);
        drive(1'b0, 4'b0011, 1'b1, 8'h64, 1'b1);
        #1;
        chk("rst.regrant_ready", 32'(req_ready), 32'b0001);
        step();
        chk("rst.regrant_src", 32'(out_src), 32'd0);
        chk("rst.regrant_data", 32'(out_pkt.data), 32'h64);
        chk("rst.regrant_valid", 32'(out_valid), 32'd1);

        drive(1'b0, 4'b0000, 1'b1, 8'h00, 1'b1);
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/packet_arbiter.md
# packet_arbiter

Round-robin arbiter that shares one `packet_t` stream between `NUM_REQ` requesters. A requester may hold the grant for a bounded burst. The block sits upstream of the packet processor/filter pair and feeds it one registered packet per cycle. Packets whose `valid` field is 0 are consumed and counted, never forwarded.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requester lanes (2..8).
- `MAX_BURST`, 4: max consecutive packets accepted from one lane per grant (1..15).
- `CNT_W`, 8: width of per-lane drop counters.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid[0:NUM_REQ-1]`  in  1 each  lane offers a packet.
- `req_pkt[0:NUM_REQ-1]`  in  `packet_t` (13b: data[7:0], tag[3:0], valid)  offered packet.
- `req_ready[0:NUM_REQ-1]`  out  1 each  lane's packet consumed this cycle.
- `out_valid`  out  1  output register holds a packet.
- `out_pkt`  out  `packet_t`  forwarded packet.
- `out_src`  out  $clog2(NUM_REQ)  lane the packet came from.
- `out_ready`  in  1  downstream accepts `out_pkt`.
- `drop_count[0:NUM_REQ-1]`  out  CNT_W each  saturating count of consumed packets with `valid=0`.

## Operation
- The output slot is free when `!out_valid || out_ready`.
- Transfer from lane i occurs when `req_valid[i] && req_ready[i]`.
- Grant selection is combinational each cycle:
  - In `BURST` with `req_valid[owner]`=1, the grant is `owner`.
  - Otherwise the grant is the first requesting lane scanning `rr_ptr, rr_ptr+1, …` modulo NUM_REQ.
  - With no requester, there is no grant.
- `req_ready[g]` = slot free && g is granted. All other ready bits are 0, and at most one ready bit is high.
- For an accepted packet with `req_pkt.valid`=1:
  - `out_pkt`, `out_src` and `out_valid`=1 are registered.
- For an accepted packet with `req_pkt.valid`=0:
  - The packet is consumed but not written.
  - `drop_count[g]` increments, saturating at 2^CNT_W−1.
  - `out_valid` clears if `out_ready` was taken this cycle.
  - Drop packets count toward the burst.
- If the slot drains without a new accept, `out_valid` goes 0.
- FSM states are `IDLE` and `BURST`, with registers `owner`, `burst_cnt` (4b) and `rr_ptr`:
  - IDLE, accept from g: `rr_ptr`←g+1 mod NUM_REQ. If MAX_BURST>1, go to `BURST` with `owner`←g, `burst_cnt`←1. Otherwise stay in IDLE.
  - BURST, accept from owner: `burst_cnt`+1. When the new count reaches MAX_BURST, go to IDLE.
  - BURST, owner's `req_valid`=0: the burst ends and the cycle re-arbitrates from `rr_ptr`.
    - An accept from lane g then follows the IDLE rule in the same cycle.
    - With no accept, go to IDLE.
  - BURST with owner requesting but slot not free: hold state.
- Reset: `out_valid`=0, `out_pkt`=0, `out_src`=0, all `drop_count`=0, state IDLE, `rr_ptr`=0, `owner`=0, `burst_cnt`=0. `req_ready` is all 0 during reset.

## Timing
- Latency is 1 cycle from accept to `out_valid`. Throughput is 1 packet/cycle when `out_ready` is held at 1.
- `req_ready` depends combinationally on `out_ready` and `req_valid`. There is no combinational path from `req_pkt` to any output.
- If `out_valid && !out_ready`, then `out_pkt`/`out_src` stay stable and all `req_ready` stay 0.
- A simultaneous drain and accept in one cycle gives a back-to-back output with no bubble.
- Reset asserted mid-burst: the next cycle is IDLE with lane 0 at highest priority, and any in-flight packet is discarded.

## Structure
- `packet_t` lives in the shared package, alongside a constant for its 13-bit width.
- Sub-module `rr_pick`: a combinational pick of the first set bit of a request vector starting at a pointer. It outputs a one-hot grant plus index.
- FSM, counters and output register stay in `packet_arbiter`.

## Test plan
- **Single lane, no backpressure.** After reset, lane 2 sends data 0x10..0x15 with valid=1 and `out_ready`=1. Required: six outputs with `out_src`=2, in order, 1-cycle latency, no bubbles.
- **All lanes requesting.** All 4 lanes request continuously, MAX_BURST=4. Required: `out_src` sequence 0,0,0,0,1,1,1,1,2,…,3 then wraps to 0.
- **Early burst end.** Lane 1 offers 2 packets then drops `req_valid`, while lane 3 is waiting. Required: `out_src`=1,1,3 with no idle cycle between.
- **Backpressure.** `out_ready`=0 for 3 cycles while `out_valid`=1. Required: `out_pkt` is stable, all `req_ready`=0, and the held packet is delivered when `out_ready` returns.
- **Drop counting.** Lane 0 sends 300 packets with valid=0 and CNT_W=8. Required: `drop_count[0]`=255 (saturated), `out_valid` never 1.
- **Reset mid-burst.** Assert `rst` while lane 1 is in BURST with `burst_cnt`=2. Required: outputs return to reset values, and the next arbitration with lanes 0 and 1 requesting grants lane 0.
